// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter sharing one req/addr_ok/data_ok memory bus between fetch and load/store.
// Data has priority; a starvation counter forces an instruction grant after STARVE_LIMIT data wins.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,

  output logic        busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state_reg;
  logic        owner_reg;        // 1 = data port, 0 = instruction port
  logic [3:0]  starve_cnt_reg;
  logic        bus_req_reg;
  logic        bus_wr_reg;
  logic [3:0]  bus_wstrb_reg;
  logic [31:0] bus_addr_reg;
  logic [31:0] bus_wdata_reg;

  logic        starve_hit;
  logic        grant_data;
  logic        grant_inst;

  always_comb begin
    starve_hit = inst_req && (starve_cnt_reg == LIMIT);
    grant_data = (state_reg == IDLE) && data_req && !starve_hit;
    grant_inst = (state_reg == IDLE) && inst_req && !grant_data;
  end

  // Handshake fan-out: index 0 = instruction port, index 1 = data port.
  logic [1:0] addr_ok_vec;
  logic [1:0] data_ok_vec;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign addr_ok_vec[gi] = (state_reg == ADDR) && (owner_reg == 1'(gi)) && bus_addr_ok;
      assign data_ok_vec[gi] = (state_reg == DATA) && (owner_reg == 1'(gi)) && bus_data_ok;
    end
  endgenerate

  assign inst_addr_ok = addr_ok_vec[0];
  assign data_addr_ok = addr_ok_vec[1];
  assign inst_data_ok = data_ok_vec[0];
  assign data_data_ok = data_ok_vec[1];

  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

  assign bus_req   = bus_req_reg;
  assign bus_wr    = bus_wr_reg;
  assign bus_wstrb = bus_wstrb_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = bus_wdata_reg;
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      starve_cnt_reg <= 4'd0;
      bus_req_reg    <= 1'b0;
      bus_wr_reg     <= 1'b0;
      bus_wstrb_reg  <= 4'd0;
      bus_addr_reg   <= 32'd0;
      bus_wdata_reg  <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_data) begin
            owner_reg     <= 1'b1;
            bus_req_reg   <= 1'b1;
            bus_wr_reg    <= data_wr;
            bus_wstrb_reg <= data_wstrb;
            bus_addr_reg  <= data_addr;
            bus_wdata_reg <= data_wdata;
            state_reg     <= ADDR;
            // Only count data wins that actually made fetch wait.
            if (!inst_req)
              starve_cnt_reg <= 4'd0;
            else if (starve_cnt_reg != LIMIT)
              starve_cnt_reg <= starve_cnt_reg + 4'd1;
          end else if (grant_inst) begin
            owner_reg      <= 1'b0;
            bus_req_reg    <= 1'b1;
            bus_wr_reg     <= 1'b0;
            bus_wstrb_reg  <= 4'd0;
            bus_addr_reg   <= inst_addr;
            bus_wdata_reg  <= 32'd0;
            state_reg      <= ADDR;
            starve_cnt_reg <= 4'd0;
          end else begin
            starve_cnt_reg <= 4'd0;
          end
        end
        ADDR: begin
          if (bus_addr_ok) begin
            bus_req_reg <= 1'b0;
            state_reg   <= DATA;
          end
        end
        DATA: begin
          if (bus_data_ok)
            state_reg <= IDLE;
        end
        default: begin
          state_reg   <= IDLE;
          bus_req_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a cycle table for single transactions and
// hand-written sequences for starvation, bus stall and reset mid-transaction.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ctl;      // {inst_req, data_req, data_wr, bus_addr_ok, bus_data_ok}
    logic [3:0]  wstrb;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [5:0]  exp;      // {bus_req, busy, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
    logic        pay;
    logic        e_bwr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_baddr;
    logic [31:0] e_bwdata;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_addr = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'd0;
    data_addr = 32'd0; data_wdata = 32'd0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
  endtask

  initial begin
    int   n_ev;
    int   ev_cyc[6];
    logic ev_own[6];
    logic exp_own[6];
    exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Single load
    vecs[0]  = '{5'b01000, 4'h0, 32'h0, 32'h1000, 32'h0, 32'h0, 6'b000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[1]  = '{5'b01000, 4'h0, 32'h0, 32'h1000, 32'h0, 32'h0, 6'b110000, 1'b1, 1'b0, 4'h0, 32'h1000, 32'h0};
    vecs[2]  = '{5'b01010, 4'h0, 32'h0, 32'h1000, 32'h0, 32'h0, 6'b110100, 1'b1, 1'b0, 4'h0, 32'h1000, 32'h0};
    vecs[3]  = '{5'b00000, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 6'b010000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[4]  = '{5'b00001, 4'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 6'b010001, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[5]  = '{5'b00000, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 6'b000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    // Store; payload change on row 8 comes after the grant and must not reach the bus
    vecs[6]  = '{5'b01100, 4'h3, 32'h0, 32'h2004, 32'h0000ABCD, 32'h0, 6'b000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[7]  = '{5'b01100, 4'h3, 32'h0, 32'h2004, 32'h0000ABCD, 32'h0, 6'b110000, 1'b1, 1'b1, 4'h3, 32'h2004, 32'h0000ABCD};
    vecs[8]  = '{5'b01110, 4'h3, 32'h0, 32'h2004, 32'hFFFFFFFF, 32'h0, 6'b110100, 1'b1, 1'b1, 4'h3, 32'h2004, 32'h0000ABCD};
    vecs[9]  = '{5'b00000, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 6'b010000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[10] = '{5'b00001, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 6'b010001, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[11] = '{5'b00000, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 6'b000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    // Simultaneous requests: data first, inst one IDLE cycle after its data_ok
    vecs[12] = '{5'b11000, 4'h0, 32'h100, 32'h3000, 32'h0, 32'h0, 6'b000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[13] = '{5'b11000, 4'h0, 32'h100, 32'h3000, 32'h0, 32'h0, 6'b110000, 1'b1, 1'b0, 4'h0, 32'h3000, 32'h0};
    vecs[14] = '{5'b11010, 4'h0, 32'h100, 32'h3000, 32'h0, 32'h0, 6'b110100, 1'b1, 1'b0, 4'h0, 32'h3000, 32'h0};
    vecs[15] = '{5'b10000, 4'h0, 32'h100, 32'h0, 32'h0, 32'h0, 6'b010000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[16] = '{5'b10001, 4'h0, 32'h100, 32'h0, 32'h0, 32'h5555AAAA, 6'b010001, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[17] = '{5'b10000, 4'h0, 32'h100, 32'h0, 32'h0, 32'h0, 6'b000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[18] = '{5'b10000, 4'h0, 32'h100, 32'h0, 32'h0, 32'h0, 6'b110000, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0};
    vecs[19] = '{5'b10010, 4'h0, 32'h100, 32'h0, 32'h0, 32'h0, 6'b111000, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0};
    vecs[20] = '{5'b00000, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 6'b010000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[21] = '{5'b00001, 4'h0, 32'h0, 32'h0, 32'h0, 32'h12345678, 6'b010010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[22] = '{5'b00000, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 6'b000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};

    // Reset state
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #2;
    chk("rst bus_req", 32'(bus_req), 32'd0);
    chk("rst bus_wr", 32'(bus_wr), 32'd0);
    chk("rst bus_wstrb", 32'(bus_wstrb), 32'd0);
    chk("rst bus_addr", bus_addr, 32'd0);
    chk("rst bus_wdata", bus_wdata, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ok flags", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven cycles
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      {inst_req, data_req, data_wr, bus_addr_ok, bus_data_ok} = vecs[i].ctl;
      data_wstrb = vecs[i].wstrb;
      inst_addr  = vecs[i].iaddr;
      data_addr  = vecs[i].daddr;
      data_wdata = vecs[i].wdata;
      bus_rdata  = vecs[i].rdata;
      #2;
      $display("row %0d: ctl=%b bus_req=%b busy=%b ok={%b%b%b%b} bus_addr=%h",
               i, vecs[i].ctl, bus_req, busy, inst_addr_ok, data_addr_ok,
               inst_data_ok, data_data_ok, bus_addr);
      chk($sformatf("row%0d bus_req", i), 32'(bus_req), 32'(vecs[i].exp[5]));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].exp[4]));
      chk($sformatf("row%0d inst_addr_ok", i), 32'(inst_addr_ok), 32'(vecs[i].exp[3]));
      chk($sformatf("row%0d data_addr_ok", i), 32'(data_addr_ok), 32'(vecs[i].exp[2]));
      chk($sformatf("row%0d inst_data_ok", i), 32'(inst_data_ok), 32'(vecs[i].exp[1]));
      chk($sformatf("row%0d data_data_ok", i), 32'(data_data_ok), 32'(vecs[i].exp[0]));
      if (vecs[i].pay) begin
        chk($sformatf("row%0d bus_wr", i), 32'(bus_wr), 32'(vecs[i].e_bwr));
        chk($sformatf("row%0d bus_wstrb", i), 32'(bus_wstrb), 32'(vecs[i].e_wstrb));
        chk($sformatf("row%0d bus_addr", i), bus_addr, vecs[i].e_baddr);
        if (vecs[i].e_bwr)
          chk($sformatf("row%0d bus_wdata", i), bus_wdata, vecs[i].e_bwdata);
      end
      if (vecs[i].exp[0])
        chk($sformatf("row%0d data_rdata", i), data_rdata, vecs[i].rdata);
      if (vecs[i].exp[1])
        chk($sformatf("row%0d inst_rdata", i), inst_rdata, vecs[i].rdata);
    end

    // Starvation: both requesters held, bus always ready -> D D D D I D, 3 cycles apart
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h200;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
    data_addr = 32'h5000; data_wdata = 32'h11;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    n_ev = 0;
    for (int c = 0; c < 30 && n_ev < 6; c++) begin
      #2;
      if (inst_addr_ok && data_addr_ok) begin
        errors++; checks++;
        $display("FAIL starve both addr_ok: got 1 1 expected one-hot");
      end else if (inst_addr_ok || data_addr_ok) begin
        ev_cyc[n_ev] = c;
        ev_own[n_ev] = data_addr_ok;
        $display("starve txn %0d: cycle %0d owner=%s bus_wr=%b bus_wstrb=%h bus_addr=%h",
                 n_ev, c, data_addr_ok ? "data" : "inst", bus_wr, bus_wstrb, bus_addr);
        if (!data_addr_ok) begin
          chk("starve inst bus_wr", 32'(bus_wr), 32'd0);
          chk("starve inst bus_wstrb", 32'(bus_wstrb), 32'd0);
          chk("starve inst bus_addr", bus_addr, 32'h200);
        end
        n_ev++;
      end
      @(negedge clk);
    end
    chk("starve txn count", 32'(n_ev), 32'd6);
    for (int k = 0; k < n_ev; k++)
      chk($sformatf("starve owner %0d", k), 32'(ev_own[k]), 32'(exp_own[k]));
    for (int k = 1; k < n_ev; k++)
      chk($sformatf("starve spacing %0d", k), 32'(ev_cyc[k] - ev_cyc[k-1]), 32'd3);
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    idle_inputs();

    // Stalled bus with spurious bus_data_ok during ADDR
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h300;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h4000;
    #2;
    chk("stall grant busy", 32'(busy), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus_data_ok = (k % 3 == 1);
      #2;
      $display("stall cycle %0d: bus_req=%b bus_addr=%h bus_data_ok=%b", k, bus_req, bus_addr, bus_data_ok);
      chk($sformatf("stall%0d bus_req", k), 32'(bus_req), 32'd1);
      chk($sformatf("stall%0d bus_addr", k), bus_addr, 32'h4000);
      chk($sformatf("stall%0d ok flags", k),
          32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
    end
    @(negedge clk);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b0; inst_req = 1'b0;
    #2;
    chk("stall release data_addr_ok", 32'(data_addr_ok), 32'd1);
    chk("stall release inst_addr_ok", 32'(inst_addr_ok), 32'd0);

    // Reset while in DATA: transaction abandoned
    @(negedge clk);
    data_req = 1'b0; bus_addr_ok = 1'b0;
    #2;
    chk("pre-reset busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b0; bus_data_ok = 1'b1;
    #2;
    $display("reset mid-op: bus_req=%b busy=%b data_data_ok=%b", bus_req, busy, data_data_ok);
    chk("midrst data_data_ok", 32'(data_data_ok), 32'd0);
    chk("midrst bus_req", 32'(bus_req), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    @(negedge clk);
    #2;
    chk("midrst hold data_data_ok", 32'(data_data_ok), 32'd0);
    @(negedge clk);
    rst = 1'b1; bus_data_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h300;
    #2;
    chk("post-rst grant cycle bus_req", 32'(bus_req), 32'd0);
    @(negedge clk);
    #2;
    chk("post-rst bus_req", 32'(bus_req), 32'd1);
    chk("post-rst bus_addr", bus_addr, 32'h300);
    chk("post-rst bus_wr", 32'(bus_wr), 32'd0);
    @(negedge clk);
    bus_addr_ok = 1'b1;
    #2;
    chk("post-rst inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    @(negedge clk);
    inst_req = 1'b0; bus_addr_ok = 1'b0;
    @(negedge clk);
    bus_data_ok = 1'b1; bus_rdata = 32'hCAFE0001;
    #2;
    $display("post-reset inst txn: inst_data_ok=%b inst_rdata=%h", inst_data_ok, inst_rdata);
    chk("post-rst inst_data_ok", 32'(inst_data_ok), 32'd1);
    chk("post-rst inst_rdata", inst_rdata, 32'hCAFE0001);
    @(negedge clk);
    bus_data_ok = 1'b0;
    #2;
    chk("post-rst final busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
